// File: rtl/cpu_pkg.sv
// Shared ALU definitions: op codes, datapath sizing, FSM encoding and
// the single-bit shift step used by both the top and the iterative shifter.
package cpu_pkg;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 4;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_SLTI = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ADDI = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_SUBI = 4'b1101;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Right shifts are arithmetic: the sign bit is replicated.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic dir);
    return dir ? {v[WIDTH-1], v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the pipeline control and the execute ALU.
interface alu_exec_unit_if;
  import cpu_pkg::*;

  logic             start;
  logic [3:0]       aluctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegalop;
  logic             busy;
  logic             ready;
  logic             done;

  modport master (
    output start, aluctrl, a, b,
    input  result, zero, overflow, illegalop, busy, ready, done
  );

  modport slave (
    input  start, aluctrl, a, b,
    output result, zero, overflow, illegalop, busy, ready, done
  );

endinterface

// File: rtl/alu_exec_unit_shifter.sv
// Iterative one-bit-per-cycle shifter; out presents the value after the next step
// so the owner can capture the final result on the same edge that the count expires.
module alu_iter_shifter
  import cpu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               dir,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               step_done,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0]   sreg_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_LEFT;
    end else if (load) begin
      sreg_q <= shift1(value, dir);
      cnt_q  <= shamt - SHAMT_W'(1);
      dir_q  <= dir;
    end else if (cnt_q != '0) begin
      sreg_q <= shift1(sreg_q, dir_q);
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end

  assign out       = shift1(sreg_q, dir_q);
  assign step_done = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative SLL/SRA with
// start/busy/done handshake; result and flags are registered and held between ops.
module alu_exec_unit
  import cpu_pkg::*;
(
  input logic             clock,
  input logic             reset,
  alu_exec_unit_if.slave  bus
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   result_q, res_d;
  logic [WIDTH-1:0]   sum, diff, sh_out;
  logic [SHAMT_W-1:0] shamt;
  logic zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, done_q, done_d;
  logic load, dir, step_done, add_ovf, sub_ovf;

  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign shamt   = bus.b[SHAMT_W-1:0];
  assign dir     = (bus.aluctrl == ALU_SRA) ? DIR_RIGHT : DIR_LEFT;
  assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1]  != bus.a[WIDTH-1]);
  assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

  alu_iter_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .dir       (dir),
    .value     (bus.a),
    .shamt     (shamt),
    .step_done (step_done),
    .out       (sh_out)
  );

  always_comb begin
    state_d = state_q;
    res_d   = result_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          ovf_d  = 1'b0;
          ill_d  = 1'b0;
          case (bus.aluctrl)
            ALU_AND:            res_d = bus.a & bus.b;
            ALU_OR:             res_d = bus.a | bus.b;
            ALU_XOR:            res_d = bus.a ^ bus.b;
            ALU_ADD, ALU_ADDI: begin
              res_d = sum;
              ovf_d = add_ovf;
            end
            ALU_SUB, ALU_SUBI: begin
              res_d = diff;
              ovf_d = sub_ovf;
            end
            ALU_SLTI:           res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            ALU_SLL, ALU_SRA: begin
              if (shamt == '0) begin
                res_d = bus.a;
              end else if (shamt == SHAMT_W'(1)) begin
                res_d = shift1(bus.a, dir);
              end else begin
                // Long shift: flags and result hold until the shifter finishes.
                done_d  = 1'b0;
                ovf_d   = ovf_q;
                ill_d   = ill_q;
                load    = 1'b1;
                state_d = ST_SHIFT;
              end
            end
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        if (step_done) begin
          res_d   = sh_out;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (res_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= res_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegalop = ill_q;
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.ready     = (state_q != ST_SHIFT);
  assign bus.done      = done_q;

endmodule
